// File: rtl/fp_div_sqrt_pkg.sv
// fp_div_sqrt_pkg: shared opcodes, FSM states, IEEE-754 format constants and operand unpacking
package fp_div_sqrt_pkg;
  localparam logic [1:0] OP_SDIV = 2'b00, OP_SSQRT = 2'b01, OP_DDIV = 2'b10, OP_DSQRT = 2'b11;
  typedef enum logic [3:0] {GET_A, GET_B, UNPACK, SPECIAL, CALC, NORM, ROUND, PACK, PUT_Z} state_t;
  localparam int S_EXP = 8, S_MAN = 23, S_BIAS = 127;
  localparam int D_EXP = 11, D_MAN = 52, D_BIAS = 1023;
  localparam logic [31:0] QNAN_S = 32'h7FC0_0000, INF_S = 32'h7F80_0000;
  localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000, INF_D = 64'h7FF0_0000_0000_0000;
  typedef struct packed {
    logic s;
    logic [12:0] e;
    logic [52:0] m;
    logic zero;
    logic inf;
    logic nan;
  } unp_t;
  // Single mantissas are left-aligned into the 53-bit double field; subnormals collapse to zero.
  function automatic unp_t unpack(input logic [63:0] x, input logic dbl);
    unp_t u;
    logic [10:0] ef;
    logic [51:0] f;
    logic emax;
    ef = dbl ? x[62:52] : {3'b0, x[30:23]};
    f = dbl ? x[51:0] : {x[22:0], 29'b0};
    emax = dbl ? &x[62:52] : &x[30:23];
    u.s = dbl ? x[63] : x[31];
    u.e = $signed({2'b0, ef}) - (dbl ? 13'(D_BIAS) : 13'(S_BIAS));
    u.m = {1'b1, f};
    u.zero = ef == 11'd0;
    u.inf = emax && f == 52'd0;
    u.nan = emax && f != 52'd0;
    return u;
  endfunction
endpackage

// File: rtl/fp_div_sqrt_unit_core.sv
// fp_iter_core: restoring shift-subtract divide / square-root engine, one result bit per cycle
module fp_iter_core #(
  parameter int W = 56,
  parameter int MW = 53
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sqrt_mode,
  input  logic [6:0]    iters,
  input  logic [MW:0]   num,
  input  logic [MW-1:0] den,
  output logic [W-1:0]  q,
  output logic          sticky,
  output logic          done
);
  logic [W+1:0] rem_q, rem_d, r2, trial, dv, base, sub, diff;
  logic [2*W-1:0] rad_q, rad_d;
  logic [W-1:0] q_q, q_d;
  logic [MW-1:0] den_q, den_d;
  logic [6:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, mode_q, mode_d, ge;
  // Load on start, then retire one quotient/root bit per cycle until the count expires.
  always_comb begin
    r2 = {rem_q[W-1:0], rad_q[2*W-1:2*W-2]};
    trial = {q_q, 2'b01};
    dv = {{(W+2-MW){1'b0}}, den_q};
    base = mode_q ? r2 : rem_q;
    sub = mode_q ? trial : dv;
    ge = base >= sub;
    diff = ge ? base - sub : base;
    rem_d = rem_q;
    rad_d = rad_q;
    q_d = q_q;
    den_d = den_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    mode_d = mode_q;
    if (start) begin
      rem_d = sqrt_mode ? '0 : {{(W+1-MW){1'b0}}, num};
      rad_d = sqrt_mode ? {num, {(2*W-MW-1){1'b0}}} : '0;
      q_d = '0;
      den_d = den;
      cnt_d = iters;
      busy_d = 1'b1;
      mode_d = sqrt_mode;
    end else if (busy_q) begin
      rem_d = mode_q ? diff : diff << 1;
      rad_d = rad_q << 2;
      q_d = {q_q[W-2:0], ge};
      cnt_d = cnt_q - 7'd1;
      busy_d = cnt_q != 7'd1;
      done_d = cnt_q == 7'd1;
    end
  end
  // Iteration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      rad_q <= '0;
      q_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      rad_q <= rad_d;
      q_q <= q_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mode_q <= mode_d;
    end
  end
  assign q = q_q;
  assign sticky = |rem_q || |rad_q;
  assign done = done_q;
endmodule

// File: rtl/fp_div_sqrt_unit.sv
// fp_div_sqrt_unit: handshaked multi-cycle IEEE-754 single/double divide and square root
module fp_div_sqrt_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  process,
  input  logic [31:0] input_as,
  input  logic [31:0] input_bs,
  input  logic [63:0] input_ad,
  input  logic [63:0] input_bd,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_zs,
  output logic [63:0] output_zd,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  import fp_div_sqrt_pkg::*;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [63:0] a_q, a_d, b_q, b_d, zd_q, zd_d, spec_z, norm_z, inf_z, zero_z;
  logic [31:0] zs_q, zs_d;
  unp_t ua_q, ua_d, ub_q, ub_d;
  logic signed [12:0] exp_q, exp_d, e_adj, be;
  logic [55:0] mant_q, mant_d, r, core_q;
  logic [53:0] rsum, num;
  logic [52:0] m_trunc;
  logic sign_q, sign_d, a_ack_q, b_ack_q, z_stb_q;
  logic dbl, sq, is_nan, is_inf, is_zero, rs, start, g, rest, lsb, core_done, core_sticky;
  fp_iter_core #(.W(56), .MW(53)) u_core (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sqrt_mode(sq),
    .iters(dbl ? 7'd56 : 7'd27),
    .num(num),
    .den(ub_q.m),
    .q(core_q),
    .sticky(core_sticky),
    .done(core_done)
  );
  // Special-case classification, operand alignment, rounding and packing datapath.
  always_comb begin
    dbl = op_q[1];
    sq = op_q[0];
    is_nan = sq ? ua_q.nan | (ua_q.s & ~ua_q.zero)
                : ua_q.nan | ub_q.nan | (ua_q.inf & ub_q.inf) | (ua_q.zero & ub_q.zero);
    is_inf = sq ? ua_q.inf : ua_q.inf | ub_q.zero;
    is_zero = sq ? ua_q.zero : ub_q.inf | ua_q.zero;
    rs = sq ? ua_q.s : ua_q.s ^ ub_q.s;
    spec_z = is_nan ? (dbl ? QNAN_D : {32'b0, QNAN_S})
           : is_inf ? (dbl ? {rs, INF_D[62:0]} : {32'b0, rs, INF_S[30:0]})
           : (dbl ? {rs, 63'b0} : {32'b0, rs, 31'b0});
    e_adj = $signed(ua_q.e) - ((sq & ua_q.e[0]) ? 13'sd1 : 13'sd0);
    num = (sq & ua_q.e[0]) ? {ua_q.m, 1'b0} : {1'b0, ua_q.m};
    r = dbl ? core_q : {core_q[26:0], 29'b0};
    g = dbl ? mant_q[2] : mant_q[31];
    rest = core_sticky | (dbl ? |mant_q[1:0] : |mant_q[30:0]);
    lsb = dbl ? mant_q[3] : mant_q[32];
    m_trunc = dbl ? mant_q[55:3] : {mant_q[55:32], 29'b0};
    rsum = {1'b0, m_trunc} + ((g & (rest | lsb)) ? (dbl ? 54'd1 : 54'h2000_0000) : 54'd0);
    be = exp_q + (dbl ? 13'sd1023 : 13'sd127);
    inf_z = dbl ? {sign_q, INF_D[62:0]} : {32'b0, sign_q, INF_S[30:0]};
    zero_z = dbl ? {sign_q, 63'b0} : {32'b0, sign_q, 31'b0};
    norm_z = be >= (dbl ? 13'sd2047 : 13'sd255) ? inf_z
           : be <= 13'sd0 ? zero_z
           : dbl ? {sign_q, be[10:0], mant_q[54:3]} : {32'b0, sign_q, be[7:0], mant_q[54:32]};
  end
  // Sequencer: handshakes, unpack, special bypass, iterate, normalize, round, pack, deliver.
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    ua_d = ua_q;
    ub_d = ub_q;
    sign_d = sign_q;
    exp_d = exp_q;
    mant_d = mant_q;
    zs_d = zs_q;
    zd_d = zd_q;
    start = 1'b0;
    case (state_q)
      GET_A: if (input_a_stb && a_ack_q) begin
        op_d = process;
        a_d = process[1] ? input_ad : {32'b0, input_as};
        state_d = process[0] ? UNPACK : GET_B;
      end
      GET_B: if (input_b_stb && b_ack_q) begin
        b_d = op_q[1] ? input_bd : {32'b0, input_bs};
        state_d = UNPACK;
      end
      UNPACK: begin
        ua_d = unpack(a_q, dbl);
        ub_d = unpack(b_q, dbl);
        state_d = SPECIAL;
      end
      SPECIAL: begin
        sign_d = rs;
        exp_d = sq ? e_adj >>> 1 : $signed(ua_q.e) - $signed(ub_q.e);
        if (is_nan | is_inf | is_zero) begin
          zs_d = dbl ? 32'b0 : spec_z[31:0];
          zd_d = dbl ? spec_z : 64'b0;
          state_d = PUT_Z;
        end else begin
          start = 1'b1;
          state_d = CALC;
        end
      end
      CALC: state_d = core_done ? NORM : CALC;
      NORM: begin
        mant_d = r[55] ? r : r << 1;
        exp_d = r[55] ? exp_q : exp_q - 13'sd1;
        state_d = ROUND;
      end
      ROUND: begin
        mant_d = {rsum[53] ? rsum[53:1] : rsum[52:0], 3'b0};
        exp_d = exp_q + (rsum[53] ? 13'sd1 : 13'sd0);
        state_d = PACK;
      end
      PACK: begin
        zs_d = dbl ? 32'b0 : norm_z[31:0];
        zd_d = dbl ? norm_z : 64'b0;
        state_d = PUT_Z;
      end
      PUT_Z: state_d = (output_z_ack && z_stb_q) ? GET_A : PUT_Z;
      default: state_d = GET_A;
    endcase
  end
  // State and datapath registers; handshake outputs follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      op_q <= 2'b00;
      a_q <= '0;
      b_q <= '0;
      ua_q <= '0;
      ub_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      mant_q <= '0;
      zs_q <= '0;
      zd_q <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      ua_q <= ua_d;
      ub_q <= ub_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      mant_q <= mant_d;
      zs_q <= zs_d;
      zd_q <= zd_d;
      a_ack_q <= state_d == GET_A;
      b_ack_q <= state_d == GET_B;
      z_stb_q <= state_d == PUT_Z;
    end
  end
  assign input_a_ack = a_ack_q;
  assign input_b_ack = b_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_zs = zs_q;
  assign output_zd = zd_q;
endmodule

// File: tb/tb_fp_div_sqrt_unit.sv
// tb_fp_div_sqrt_unit: directed self-checking bench for the divide/sqrt unit
module tb_fp_div_sqrt_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] process = 2'b00;
  logic [31:0] input_as = '0, input_bs = '0;
  logic [63:0] input_ad = '0, input_bd = '0;
  logic input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
  logic input_a_ack, input_b_ack, output_z_stb;
  logic [31:0] output_zs;
  logic [63:0] output_zd;
  int checks = 0, errors = 0, b_ack_cnt = 0;
  logic [1:0] sp_op [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3};
  logic [63:0] sp_a [10] = '{64'h3F800000, 64'h0, 64'hC0000000, 64'h7F000000, 64'h80000000,
                             64'h7F800000, 64'h7FF0000000000001, 64'h00000001, 64'h00800000,
                             64'hC000000000000000};
  logic [63:0] sp_b [10] = '{64'h0, 64'h0, 64'h7F800000, 64'h00800000, 64'h0, 64'h0,
                             64'h3FF0000000000000, 64'h3F800000, 64'h40000000, 64'h0};
  logic [63:0] sp_z [10] = '{64'h7F800000, 64'h7FC00000, 64'h80000000, 64'h7F800000, 64'h80000000,
                             64'h7F800000, 64'h7FF8000000000000, 64'h0, 64'h0, 64'h7FF8000000000000};
  int sp_lat [10] = '{4, 4, 4, 36, 4, 4, 4, 4, 36, 4};

  fp_div_sqrt_unit dut (
    .clk(clk), .rst(rst), .process(process),
    .input_as(input_as), .input_bs(input_bs), .input_ad(input_ad), .input_bd(input_bd),
    .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_zs(output_zs), .output_zd(output_zd),
    .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (input_b_ack) b_ack_cnt++;

  task automatic send_a(input logic [1:0] p, input logic [63:0] v);
    int n = 0;
    while (!input_a_ack && n < 50) begin @(posedge clk); #1; n++; end
    if (!input_a_ack) begin checks++; errors++; $display("FAIL a_ack_timeout: input_a_ack=%b required 1", input_a_ack); end
    process = p; input_as = v[31:0]; input_ad = v; input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] v);
    int n = 0;
    while (!input_b_ack && n < 50) begin @(posedge clk); #1; n++; end
    if (!input_b_ack) begin checks++; errors++; $display("FAIL b_ack_timeout: input_b_ack=%b required 1", input_b_ack); end
    input_bs = v[31:0]; input_bd = v; input_b_stb = 1'b1;
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  task automatic wait_z(output int n);
    n = 0;
    while (!output_z_stb && n < 200) begin @(posedge clk); #1; n++; end
    if (!output_z_stb) begin checks++; errors++; $display("FAIL z_timeout: output_z_stb=%b required 1", output_z_stb); end
  endtask

  task automatic ack_z;
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_a_ack: got %b expected 0", input_a_ack); end
    checks++; if (input_b_ack !== 1'b0) begin errors++; $display("FAIL reset_b_ack: got %b expected 0", input_b_ack); end
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_z_stb: got %b expected 0", output_z_stb); end
    checks++; if (output_zs !== 32'h0) begin errors++; $display("FAIL reset_zs: got %h expected 0", output_zs); end
    checks++; if (output_zd !== 64'h0) begin errors++; $display("FAIL reset_zd: got %h expected 0", output_zd); end
    rst = 1'b0;
    #1;
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL release_a_ack_early: got %b expected 0", input_a_ack); end
    @(posedge clk); #1;
    checks++; if (input_a_ack !== 1'b1) begin errors++; $display("FAIL release_a_ack: got %b expected 1", input_a_ack); end
  endtask

  task automatic test_sdiv;
    int n;
    send_a(2'b00, 64'h40C00000);
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL sdiv_a_ack_drop: got %b expected 0", input_a_ack); end
    send_b(64'h40000000);
    process = 2'b11; input_a_stb = 1'b1; input_as = 32'h3F800000;
    wait_z(n);
    input_a_stb = 1'b0; process = 2'b00;
    checks++; if (output_zs !== 32'h40400000) begin errors++; $display("FAIL sdiv_zs: got %h expected 40400000", output_zs); end
    checks++; if (output_zd !== 64'h0) begin errors++; $display("FAIL sdiv_zd: got %h expected 0", output_zd); end
    checks++; if (n > 36) begin errors++; $display("FAIL sdiv_latency: got %0d expected <=36", n); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (output_z_stb !== 1'b1) begin errors++; $display("FAIL sdiv_hold_stb: got %b expected 1", output_z_stb); end
    checks++; if (output_zs !== 32'h40400000) begin errors++; $display("FAIL sdiv_hold_zs: got %h expected 40400000", output_zs); end
    ack_z;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL sdiv_stb_drop: got %b expected 0", output_z_stb); end
    checks++; if (output_zs !== 32'h40400000) begin errors++; $display("FAIL sdiv_keep_zs: got %h expected 40400000", output_zs); end
  endtask

  task automatic test_ddiv;
    int n;
    send_a(2'b10, 64'h3FF0000000000000);
    send_b(64'h4008000000000000);
    wait_z(n);
    checks++; if (output_zd !== 64'h3FD5555555555555) begin errors++; $display("FAIL ddiv_zd: got %h expected 3fd5555555555555", output_zd); end
    checks++; if (output_zs !== 32'h0) begin errors++; $display("FAIL ddiv_zs: got %h expected 0", output_zs); end
    checks++; if (n > 66) begin errors++; $display("FAIL ddiv_latency: got %0d expected <=66", n); end
    ack_z;
  endtask

  task automatic test_ssqrt;
    int n, c0;
    c0 = b_ack_cnt;
    send_a(2'b01, 64'h40800000);
    input_b_stb = 1'b1;
    wait_z(n);
    input_b_stb = 1'b0;
    checks++; if (output_zs !== 32'h40000000) begin errors++; $display("FAIL ssqrt4_zs: got %h expected 40000000", output_zs); end
    checks++; if (n > 36) begin errors++; $display("FAIL ssqrt_latency: got %0d expected <=36", n); end
    ack_z;
    send_a(2'b01, 64'hBF800000);
    wait_z(n);
    checks++; if (output_zs !== 32'h7FC00000) begin errors++; $display("FAIL ssqrt_neg_zs: got %h expected 7fc00000", output_zs); end
    ack_z;
    checks++; if (b_ack_cnt !== c0) begin errors++; $display("FAIL ssqrt_b_ack: got %0d b_ack cycles expected %0d", b_ack_cnt, c0); end
  endtask

  task automatic test_dsqrt;
    int n;
    send_a(2'b11, 64'h4000000000000000);
    wait_z(n);
    checks++; if (output_zd !== 64'h3FF6A09E667F3BCD) begin errors++; $display("FAIL dsqrt_zd: got %h expected 3ff6a09e667f3bcd", output_zd); end
    checks++; if (n > 66) begin errors++; $display("FAIL dsqrt_latency: got %0d expected <=66", n); end
    ack_z;
  endtask

  task automatic test_specials;
    int n;
    for (int i = 0; i < 10; i++) begin
      send_a(sp_op[i], sp_a[i]);
      if (!sp_op[i][0]) send_b(sp_b[i]);
      wait_z(n);
      if (sp_op[i][1]) begin
        checks++; if (output_zd !== sp_z[i]) begin errors++; $display("FAIL special%0d_zd: got %h expected %h", i, output_zd, sp_z[i]); end
        checks++; if (output_zs !== 32'h0) begin errors++; $display("FAIL special%0d_zs: got %h expected 0", i, output_zs); end
      end else begin
        checks++; if (output_zs !== sp_z[i][31:0]) begin errors++; $display("FAIL special%0d_zs: got %h expected %h", i, output_zs, sp_z[i][31:0]); end
        checks++; if (output_zd !== 64'h0) begin errors++; $display("FAIL special%0d_zd: got %h expected 0", i, output_zd); end
      end
      checks++; if (n > sp_lat[i]) begin errors++; $display("FAIL special%0d_latency: got %0d expected <=%0d", i, n, sp_lat[i]); end
      ack_z;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    send_a(2'b00, 64'h40C00000);
    send_b(64'h40000000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL midrst_a_ack: got %b expected 0", input_a_ack); end
    checks++; if (input_b_ack !== 1'b0) begin errors++; $display("FAIL midrst_b_ack: got %b expected 0", input_b_ack); end
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL midrst_z_stb: got %b expected 0", output_z_stb); end
    checks++; if (output_zs !== 32'h0) begin errors++; $display("FAIL midrst_zs: got %h expected 0", output_zs); end
    @(posedge clk); #1;
    rst = 1'b0;
    send_a(2'b00, 64'h40C00000);
    send_b(64'h40000000);
    process = 2'b11;
    wait_z(n);
    checks++; if (output_zs !== 32'h40400000) begin errors++; $display("FAIL midrst_result_zs: got %h expected 40400000", output_zs); end
    checks++; if (output_zd !== 64'h0) begin errors++; $display("FAIL midrst_result_zd: got %h expected 0", output_zd); end
    ack_z;
    process = 2'b00;
  endtask

  task automatic test_back_to_back;
    int n;
    output_z_ack = 1'b1;
    send_a(2'b00, 64'h40C00000);
    send_b(64'h40000000);
    wait_z(n);
    checks++; if (output_zs !== 32'h40400000) begin errors++; $display("FAIL b2b_first_zs: got %h expected 40400000", output_zs); end
    @(posedge clk); #1;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle_stb: got %b expected 0", output_z_stb); end
    output_z_ack = 1'b0;
    send_a(2'b10, 64'h3FF0000000000000);
    send_b(64'h4000000000000000);
    wait_z(n);
    checks++; if (output_zd !== 64'h3FE0000000000000) begin errors++; $display("FAIL b2b_second_zd: got %h expected 3fe0000000000000", output_zd); end
    checks++; if (output_zs !== 32'h0) begin errors++; $display("FAIL b2b_second_zs: got %h expected 0", output_zs); end
    ack_z;
  endtask

  initial begin
    test_reset;
    test_sdiv;
    test_ddiv;
    test_ssqrt;
    test_dsqrt;
    test_specials;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
